// File: rtl/axi_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU read arbiter.
package axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } rd_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Owner one-hot is {m1, m0}
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [3:0]  id;
    } r_beat_t;

endpackage

// File: rtl/axi_arbiter_rr_picker.sv
// Two-input round-robin grant: a lone requester always wins, a tie goes to
// whichever side was not served last.
module rr_picker
    import axi_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_m1,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last_m1 ? OWN_M0 : OWN_M1;
    end

endmodule

// File: rtl/axi_arbiter.sv
// Single-outstanding read arbiter between IFU (m0) and LSU (m1) onto one AXI4
// port; LSU write channels bypass the arbiter entirely.
module axi_arbiter
    import axi_arbiter_pkg::*;
#(
    parameter bit IFU_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [3:0]  m0_arid,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [1:0]  m0_rresp,
    output logic [63:0] m0_rdata,
    output logic        m0_rlast,
    output logic [3:0]  m0_rid,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [3:0]  m1_arid,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [1:0]  m1_rresp,
    output logic [63:0] m1_rdata,
    output logic        m1_rlast,
    output logic [3:0]  m1_rid,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_awaddr,
    input  logic [3:0]  m1_awid,
    input  logic [7:0]  m1_awlen,
    input  logic [2:0]  m1_awsize,
    input  logic [1:0]  m1_awburst,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    input  logic [63:0] m1_wdata,
    input  logic [7:0]  m1_wstrb,
    input  logic        m1_wlast,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    output logic [1:0]  m1_bresp,
    output logic [3:0]  m1_bid,
    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic [1:0]  s_rresp,
    input  logic [63:0] s_rdata,
    input  logic        s_rlast,
    input  logic [3:0]  s_rid,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_awaddr,
    output logic [3:0]  s_awid,
    output logic [7:0]  s_awlen,
    output logic [2:0]  s_awsize,
    output logic [1:0]  s_awburst,
    output logic        s_wvalid,
    input  logic        s_wready,
    output logic [63:0] s_wdata,
    output logic [7:0]  s_wstrb,
    output logic        s_wlast,
    input  logic        s_bvalid,
    output logic        s_bready,
    input  logic [1:0]  s_bresp,
    input  logic [3:0]  s_bid,
    output logic        err_o,
    output logic [1:0]  owner_o
);

    rd_state_e   state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        last_m1_q, last_m1_d;
    logic [1:0]  gnt;
    logic        sel_m1, ar_vld, r_rdy;
    ar_req_t     m0_ar, m1_ar, sel_ar;
    r_beat_t     s_beat;

    assign m0_ar  = '{m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst};
    assign m1_ar  = '{m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst};
    assign s_beat = '{s_rdata, s_rlast, s_rresp, s_rid};
    assign sel_m1 = (owner_q == OWN_M1);

    rr_picker u_picker (
        .req     ({m1_arvalid, m0_arvalid}),
        .last_m1 (last_m1_q),
        .gnt     (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            last_m1_q <= IFU_FIRST;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            last_m1_q <= last_m1_d;
        end
    end

    // Every read-side output is forced low while reset is held.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        last_m1_d = last_m1_q;
        sel_ar    = sel_m1 ? m1_ar : m0_ar;
        ar_vld    = sel_m1 ? m1_arvalid : m0_arvalid;
        r_rdy     = sel_m1 ? m1_rready : m0_rready;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        {s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst} = '0;
        {m0_rvalid, m0_rdata, m0_rlast, m0_rresp, m0_rid} = '0;
        {m1_rvalid, m1_rdata, m1_rlast, m1_rresp, m1_rid} = '0;
        s_rready = 1'b0;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt != OWN_NONE) begin
                        owner_d = gnt;
                        state_d = ST_AR;
                    end
                end
                ST_AR: begin
                    s_arvalid = ar_vld;
                    {s_araddr, s_arid, s_arlen, s_arsize, s_arburst} = sel_ar;
                    if (sel_m1) m1_arready = s_arready;
                    else        m0_arready = s_arready;
                    if (ar_vld && s_arready) begin
                        cnt_d   = sel_ar.len;
                        state_d = ST_R;
                    end
                end
                ST_R: begin
                    s_rready = r_rdy;
                    if (sel_m1) {m1_rvalid, m1_rdata, m1_rlast, m1_rresp, m1_rid} = {s_rvalid, s_beat};
                    else        {m0_rvalid, m0_rdata, m0_rlast, m0_rresp, m0_rid} = {s_rvalid, s_beat};
                    if (s_rvalid && r_rdy) begin
                        cnt_d = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
                        if (s_rlast) begin
                            if (cnt_q != 8'd0) err_d = 1'b1;
                            state_d   = ST_IDLE;
                            owner_d   = OWN_NONE;
                            last_m1_d = sel_m1;
                        end else if (cnt_q == 8'd0) begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        {s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst} = '0;
        {s_wvalid, s_wdata, s_wstrb, s_wlast} = '0;
        {m1_bvalid, m1_bresp, m1_bid} = '0;
        {m1_awready, m1_wready, s_bready} = '0;
        if (rst) begin
            {s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst} =
                {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst};
            {s_wvalid, s_wdata, s_wstrb, s_wlast} = {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast};
            {m1_bvalid, m1_bresp, m1_bid} = {s_bvalid, s_bresp, s_bid};
            {m1_awready, m1_wready, s_bready} = {s_awready, s_wready, m1_bready};
        end
    end

    assign err_o   = rst & err_q;
    assign owner_o = rst ? owner_q : OWN_NONE;

endmodule

// File: tb/tb_axi_arbiter.sv
// Scoreboard bench for axi_arbiter: directed reads/writes, expected beats
// queued at issue and checked by a monitor on each handshake.
module tb_axi_arbiter;
    import axi_arbiter_pkg::*;

    logic        clk, rst;
    logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [31:0] m0_araddr, m1_araddr;
    logic [3:0]  m0_arid, m1_arid;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [63:0] m0_rdata, m1_rdata;
    logic [3:0]  m0_rid, m1_rid;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr;
    logic [3:0]  m1_awid, m1_bid;
    logic [7:0]  m1_awlen, m1_wstrb;
    logic [2:0]  m1_awsize;
    logic [1:0]  m1_awburst, m1_bresp;
    logic [63:0] m1_wdata;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic [63:0] s_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awid, s_bid;
    logic [7:0]  s_awlen, s_wstrb;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic [63:0] s_wdata;
    logic        err_o;
    logic [1:0]  owner_o;

    int tests = 0, fails = 0;
    int slv_beats = 0;
    logic [1:0] slv_resp = RESP_OKAY;
    bit tgl = 0;
    r_beat_t m0_q[$], m1_q[$];
    ar_req_t ar_q[$];
    logic [35:0] aw_q[$];
    logic [71:0] w_q[$];
    logic [5:0]  b_q[$];

    axi_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
        .m0_rlast(m0_rlast), .m0_rid(m0_rid),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata),
        .m1_rlast(m1_rlast), .m1_rid(m1_rid),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .m1_bid(m1_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_bid(s_bid),
        .err_o(err_o), .owner_o(owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic ar_req_t mk_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        return '{a, id, len, 3'd3, BURST_INCR};
    endfunction

    // Drive one AR request and queue the beats the slave model will return.
    task automatic issue_rd(input bit m, input logic [31:0] a, input logic [3:0] id,
                            input logic [7:0] len, input int nb);
        bit hs = 0;
        r_beat_t b;
        for (int i = 0; i < nb; i++) begin
            b = '{{a, 32'(i)}, (i == nb - 1), slv_resp, id};
            if (m) m1_q.push_back(b); else m0_q.push_back(b);
        end
        if (m) begin
            {m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst} = mk_ar(a, id, len);
            m1_arvalid = 1'b1;
        end else begin
            {m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = mk_ar(a, id, len);
            m0_arvalid = 1'b1;
        end
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = m ? m1_arready : m0_arready;
        end
        if (!hs) chk("ar handshake timeout", 0, 1);
        @(posedge clk); #1;
        if (m) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [63:0] d,
                            input logic [7:0] strb);
        bit aw_done = 0, w_done = 0, ahs, whs;
        {m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = {a, id, 8'd0, 3'd3, BURST_INCR};
        {m1_wdata, m1_wstrb, m1_wlast} = {d, strb, 1'b1};
        m1_awvalid = 1'b1;
        m1_wvalid  = 1'b1;
        for (int t = 0; t < 100 && !(aw_done && w_done); t++) begin
            @(negedge clk);
            ahs = m1_awvalid && m1_awready;
            whs = m1_wvalid && m1_wready;
            @(posedge clk); #1;
            if (ahs) begin m1_awvalid = 1'b0; aw_done = 1; end
            if (whs) begin m1_wvalid = 1'b0; w_done = 1; end
        end
        chk("write handshakes", {aw_done, w_done}, 2'b11);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && owner_o != OWN_NONE; t++) @(negedge clk);
        chk("return to idle", owner_o, OWN_NONE);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Downstream read slave: beat i carries {araddr, i}; slv_beats overrides the count.
    initial begin : rd_slave
        logic [31:0] a;
        logic [3:0]  id;
        int n;
        bit ok;
        s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rid = '0; s_rresp = '0;
        forever begin
            @(negedge clk);
            if (rst && s_arvalid && s_arready) begin
                a = s_araddr; id = s_arid;
                n = (slv_beats != 0) ? slv_beats : int'(s_arlen) + 1;
                @(posedge clk); #1;
                for (int i = 0; i < n; i++) begin
                    s_rvalid = 1'b1; s_rdata = {a, 32'(i)}; s_rid = id;
                    s_rresp = slv_resp; s_rlast = (i == n - 1);
                    ok = 0;
                    for (int t = 0; t < 200; t++) begin
                        @(negedge clk);
                        if (!rst) break;
                        if (s_rready) begin ok = 1; break; end
                    end
                    @(posedge clk); #1;
                    if (!ok) break;
                end
                s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
            end
        end
    end

    initial begin : wr_slave
        bit got_aw = 0, got_w = 0;
        logic [3:0] id = '0;
        s_bvalid = 0; s_bresp = '0; s_bid = '0;
        forever begin
            @(negedge clk);
            if (rst && s_awvalid && s_awready) begin got_aw = 1; id = s_awid; end
            if (rst && s_wvalid && s_wready && s_wlast) got_w = 1;
            if (got_aw && got_w) begin
                @(posedge clk); #1;
                s_bvalid = 1'b1; s_bid = id; s_bresp = RESP_OKAY;
                for (int t = 0; t < 100; t++) begin @(negedge clk); if (s_bready) break; end
                @(posedge clk); #1;
                s_bvalid = 1'b0;
                got_aw = 0; got_w = 0;
            end
        end
    end

    initial begin : rready_toggle
        forever begin
            @(posedge clk); #1;
            if (tgl) m1_rready = ~m1_rready;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (s_arvalid && s_arready) begin
                if (ar_q.size() == 0) chk("s_ar unexpected request", {s_araddr, s_arid}, 0);
                else chk("s_ar request order", {s_araddr, s_arid, s_arlen, s_arsize, s_arburst}, ar_q.pop_front());
            end
            if (m0_rvalid && m0_rready) begin
                if (m0_q.size() == 0) chk("m0_r unexpected beat", m0_rdata, 0);
                else chk("m0_r beat", {m0_rdata, m0_rlast, m0_rresp, m0_rid}, m0_q.pop_front());
            end
            if (m1_rvalid && m1_rready) begin
                if (m1_q.size() == 0) chk("m1_r unexpected beat", m1_rdata, 0);
                else chk("m1_r beat", {m1_rdata, m1_rlast, m1_rresp, m1_rid}, m1_q.pop_front());
            end
            if (s_awvalid && s_awready) begin
                if (aw_q.size() == 0) chk("s_aw unexpected", s_awaddr, 0);
                else chk("s_aw fields", {s_awaddr, s_awid}, aw_q.pop_front());
            end
            if (s_wvalid && s_wready) begin
                if (w_q.size() == 0) chk("s_w unexpected", s_wdata, 0);
                else chk("s_w fields", {s_wdata, s_wstrb}, w_q.pop_front());
            end
            if (m1_bvalid && m1_bready) begin
                if (b_q.size() == 0) chk("m1_b unexpected", m1_bid, 0);
                else chk("m1_b response", {m1_bid, m1_bresp}, b_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bad;
        rst = 1'b0;
        {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = '0;
        {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst} = '0;
        {m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = '0;
        {m1_wdata, m1_wstrb, m1_wlast} = '0;
        m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        // Requests held during reset must not leak through
        m0_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("outputs during reset",
                {m0_arready, m1_arready, s_arvalid, s_awvalid, s_wvalid, m1_awready, m1_wready,
                 s_rready, m0_rvalid, m1_rvalid, m1_bvalid, s_bready, err_o, owner_o}, 0);
        end
        m0_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post-reset owner/err", {owner_o, err_o}, 3'b000);

        // m0 alone, single beat, cycle-exact latency
        @(posedge clk); #1;
        ar_q.push_back(mk_ar(32'h8000_0000, 4'd1, 8'd0));
        m0_q.push_back('{{32'h8000_0000, 32'd0}, 1'b1, RESP_OKAY, 4'd1});
        {m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = mk_ar(32'h8000_0000, 4'd1, 8'd0);
        m0_arvalid = 1'b1;
        @(negedge clk);
        chk("s_arvalid low in idle", s_arvalid, 1'b0);
        @(negedge clk);
        chk("s_arvalid on cycle 2", {s_arvalid, m0_arready, m1_arready, owner_o}, {3'b110, OWN_M0});
        @(posedge clk); #1 m0_arvalid = 1'b0;
        wait_idle();
        chk("single beat: err_o", err_o, 1'b0);

        // Simultaneous requests after reset: m0, m1, then m0 again on re-request
        apply_reset();
        ar_q.push_back(mk_ar(32'h8000_0100, 4'd2, 8'd1));
        ar_q.push_back(mk_ar(32'h8000_0200, 4'd3, 8'd0));
        fork
            issue_rd(0, 32'h8000_0100, 4'd2, 8'd1, 2);
            issue_rd(1, 32'h8000_0200, 4'd3, 8'd0, 1);
        join
        wait_idle();
        ar_q.push_back(mk_ar(32'h8000_0110, 4'd4, 8'd0));
        ar_q.push_back(mk_ar(32'h8000_0210, 4'd5, 8'd0));
        fork
            issue_rd(0, 32'h8000_0110, 4'd4, 8'd0, 1);
            issue_rd(1, 32'h8000_0210, 4'd5, 8'd0, 1);
        join
        wait_idle();

        // m1 burst of 4 with rready toggling, m0 request arriving mid-burst
        tgl = 1;
        ar_q.push_back(mk_ar(32'h8000_0400, 4'd6, 8'd3));
        ar_q.push_back(mk_ar(32'h8000_0300, 4'd7, 8'd0));
        issue_rd(1, 32'h8000_0400, 4'd6, 8'd3, 4);
        bad = 0;
        fork
            issue_rd(0, 32'h8000_0300, 4'd7, 8'd0, 1);
            for (int t = 0; t < 100 && m1_q.size() != 0; t++) begin
                @(negedge clk); #1;
                if (m1_q.size() != 0 && (owner_o != OWN_M1 || m0_rvalid)) bad++;
            end
        join
        tgl = 0;
        @(posedge clk); #1 m1_rready = 1'b1;
        wait_idle();
        chk("m1 burst held grant", bad, 0);

        // Early rlast on beat 2 of arlen=3: sticky error
        slv_beats = 2;
        ar_q.push_back(mk_ar(32'h8000_0500, 4'd8, 8'd3));
        issue_rd(1, 32'h8000_0500, 4'd8, 8'd3, 2);
        wait_idle();
        slv_beats = 0;
        chk("early rlast sets err_o", err_o, 1'b1);
        ar_q.push_back(mk_ar(32'h8000_0600, 4'd9, 8'd0));
        issue_rd(0, 32'h8000_0600, 4'd9, 8'd0, 1);
        wait_idle();
        chk("err_o sticky", err_o, 1'b1);
        apply_reset();
        @(negedge clk);
        chk("err_o cleared by reset", err_o, 1'b0);

        // Extra beat past the counter: error, FSM waits for rlast
        slv_beats = 3;
        ar_q.push_back(mk_ar(32'h8000_0700, 4'd10, 8'd0));
        issue_rd(0, 32'h8000_0700, 4'd10, 8'd0, 3);
        wait_idle();
        slv_beats = 0;
        chk("missing rlast sets err_o", err_o, 1'b1);
        apply_reset();

        // SLVERR/DECERR pass through without flagging
        slv_resp = RESP_SLVERR;
        ar_q.push_back(mk_ar(32'h8000_0800, 4'd11, 8'd1));
        issue_rd(1, 32'h8000_0800, 4'd11, 8'd1, 2);
        wait_idle();
        slv_resp = RESP_DECERR;
        ar_q.push_back(mk_ar(32'h8000_0900, 4'd12, 8'd0));
        issue_rd(0, 32'h8000_0900, 4'd12, 8'd0, 1);
        wait_idle();
        slv_resp = RESP_OKAY;
        chk("error responses leave err_o", err_o, 1'b0);

        // Reset during beat 1 abandons the burst
        m0_rready = 1'b0;
        ar_q.push_back(mk_ar(32'h8000_0A00, 4'd13, 8'd3));
        issue_rd(0, 32'h8000_0A00, 4'd13, 8'd3, 0);
        for (int t = 0; t < 20 && !m0_rvalid; t++) @(negedge clk);
        chk("beat 1 presented", {m0_rvalid, m0_rdata}, {1'b1, 32'h8000_0A00, 32'd0});
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("valids low in reset", {m0_rvalid, m1_rvalid, s_arvalid, s_rready, owner_o}, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("idle after mid-burst reset", {owner_o, err_o, m0_rvalid, s_rready, s_arvalid}, 0);
        m0_rready = 1'b1;
        repeat (2) @(negedge clk);
        chk("no beats after abandon", {owner_o, m0_rvalid}, 0);

        // LSU write concurrent with an m0 read burst
        ar_q.push_back(mk_ar(32'h8000_2000, 4'd14, 8'd3));
        aw_q.push_back({32'h8000_1000, 4'd5});
        w_q.push_back({64'h0000_0000_DEAD_BEEF, 8'h0F});
        b_q.push_back({4'd5, RESP_OKAY});
        fork
            issue_rd(0, 32'h8000_2000, 4'd14, 8'd3, 4);
            do_write(32'h8000_1000, 4'd5, 64'h0000_0000_DEAD_BEEF, 8'h0F);
        join
        wait_idle();
        for (int t = 0; t < 50 && b_q.size() != 0; t++) @(negedge clk);
        chk("concurrent rd/wr err_o", err_o, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained",
            m0_q.size() + m1_q.size() + ar_q.size() + aw_q.size() + w_q.size() + b_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 Parameter IFU_FIRST, default 1, gives the priority of the first arbitration after reset (1 = IFU m0, 0 = LSU m1).
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-low.
REQ-004 Port group m0_ar*, IFU side, bundle:
  - inputs: arvalid, araddr[31:0], arid[3:0], arlen[7:0], arsize[2:0], arburst[1:0];
  - output: arready.
REQ-005 Port group m0_r*, IFU side, bundle:
  - outputs: rvalid, rresp[1:0], rdata[63:0], rlast, rid[3:0];
  - input: rready.
REQ-006 Port group m1_ar* and m1_r*, LSU side: same bundles and directions as m0.
REQ-007 Port group m1_aw*/m1_w*/m1_b*, LSU side: full AXI4 write channels (aw, w, b).
REQ-008 Port group s_ar*/s_r*/s_aw*/s_w*/s_b*, downstream AXI4 master port: the mirror image of the upstream bundles.
REQ-009 Port err_o, output, 1: sticky burst-length violation flag.
REQ-010 Port owner_o, output, 2: current read owner, one-hot {m1,m0}; 00 when idle.

Function
REQ-011 The read path SHALL use the FSM states IDLE, AR, R.
REQ-012 IDLE behaviour:
  - If any mX_arvalid=1, latch the grant and go to AR next cycle; arbitration latency is 1 cycle.
  - Downstream s_arvalid=0 while in IDLE.
REQ-013 Arbitration is round-robin:
  - With both requesting, grant the requester not served last.
  - With one requesting, grant it regardless of history.
  - The first arbitration after reset follows IFU_FIRST.
REQ-014 AR behaviour:
  - s_ar* = owner's ar* fields, combinationally.
  - Owner arready = s_arready; non-owner arready = 0.
  - On s_arvalid&s_arready, load beat counter = arlen and go to R.
REQ-015 R behaviour:
  - Owner r* = s_r*; owner rready drives s_rready.
  - Non-owner rvalid=0 and rdata=0.
  - Each beat (s_rvalid&s_rready) decrements the beat counter.
REQ-016 Leaving R:
  - The beat with rlast=1 returns the FSM to IDLE.
  - That beat updates last-served to the current owner.
  - owner_o clears on the cycle after that beat.
REQ-017 The grant SHALL NOT change between AR acceptance and the rlast beat, even if the other requester raises arvalid.
REQ-018 err_o SHALL set on either of two conditions:
  - rlast=1 while beat counter ≠ 0;
  - a beat with rlast=0 while beat counter = 0.
  - In the second case, stay in R until rlast arrives.
REQ-019 The beat counter is 8 bits, decrements saturate at 0, and wrap-around is not permitted.
REQ-020 Write channels SHALL pass between m1 and s combinationally with zero latency, independent of the read FSM.
REQ-021 Reads and writes MAY be in flight concurrently.
REQ-022 rresp values SLVERR and DECERR SHALL pass to the owner unchanged and SHALL NOT set err_o.
REQ-023 The module SHALL not accept or track more than one outstanding read at a time.

Reset
REQ-024 While rst=0, at the next edge:
  - FSM = IDLE, owner_o = 00, beat counter = 0, err_o = 0;
  - last-served = m1 if IFU_FIRST=1, else m0.
REQ-025 During reset, all outputs SHALL be 0, including every valid, every ready and err_o.
REQ-026 Reset asserted mid-burst SHALL abandon the burst with no further beats routed; the downstream port is reset together with the arbiter.

Structure
REQ-027 The shared defines file SHALL hold:
  - the FSM state encodings;
  - the AXI burst and response constants;
  - the owner one-hot encodings.
REQ-028 One sub-module SHALL be used: rr_picker, a combinational two-input round-robin grant given the request vector and last-served.
  - The FSM, beat counter and muxing stay in axi_arbiter.

Verification
REQ-029 m0 alone: araddr=0x8000_0000, arlen=0 -> s_arvalid on cycle 2, one beat routed to m0, return to IDLE, err_o=0.
REQ-030 m0 and m1 requesting in the same cycle after reset (IFU_FIRST=1) -> m0 served first, then m1; with both re-requesting, m0 is served next.
REQ-031 m1 burst arlen=3 with rready toggling 1/0 -> exactly 4 beats routed to m1 and m0 sees rvalid=0 throughout; m0 arvalid raised mid-burst is granted only after the 4th beat.
REQ-032 Downstream asserts rlast on beat 2 of an arlen=3 burst -> err_o=1 held until reset, FSM returns to IDLE.
REQ-033 rst=0 during beat 1 of a burst -> next cycle FSM=IDLE, owner_o=00, all valids 0.
REQ-034 LSU write (awaddr=0x8000_1000, wdata=0xDEAD_BEEF, wstrb=0x0F) concurrent with an m0 read burst -> B response returned to m1 and read data to m0, with no interference.
